// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_pkg
// Purpose : Shared types and constants for the seven-segment scan driver.
// Rev     : 1.0  initial release
// ============================================================================
package seven_seg_pkg;

   typedef enum logic [0:0] {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   localparam int         MAX_DIGITS = 8;
   localparam logic [6:0] SEG_OFF    = 7'h7F;
   // Slice [NUM_DIGITS-1:0] for an all-dark digit enable bus.
   localparam logic [MAX_DIGITS-1:0] DIG_OFF = '1;

   localparam int DEF_NUM_DIGITS   = 6;
   localparam int DEF_SCAN_DIV     = 5000;
   localparam int DEF_BLANK_CYCLES = 16;
   localparam int DEF_BLINK_FRAMES = 250;

endpackage
`default_nettype wire

// File: rtl/seven_seg_pwm.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_pwm
// Purpose : 4-bit free-running PWM counter with brightness compare.
// Rev     : 1.0  initial release
// ============================================================================
module seven_seg_pwm (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear,
   input  logic [3:0] brightness,
   output logic       lit
);

   logic [3:0] r_pwm_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pwm_cnt <= 4'd0;
      end else if (clear) begin
         r_pwm_cnt <= 4'd0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 4'd1;
      end
   end

   // Level 15 is fully on; otherwise on for the first 'brightness' of 16 steps.
   assign lit = (brightness == 4'hF) || (r_pwm_cnt < brightness);

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_scan_driver
// Purpose : Time-multiplexed common-anode 7-segment driver with anti-ghost
//           blanking and PWM brightness. Optional blink: SEVEN_SEG_BLINK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
   parameter int SCAN_DIV     = DEF_SCAN_DIV,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
   parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic [NUM_DIGITS*7-1:0] seg_in,
   input  logic [3:0]              brightness,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [6:0]              seg_n,
   output logic [NUM_DIGITS-1:0]   dig_n,
   output logic                    frame_tick
);

   localparam int c_slot_w = $clog2(SCAN_DIV);
   localparam int c_dig_w  = $clog2(NUM_DIGITS);
   localparam logic [c_slot_w-1:0]   c_blank_last = c_slot_w'(BLANK_CYCLES - 1);
   localparam logic [c_slot_w-1:0]   c_slot_last  = c_slot_w'(SCAN_DIV - 1);
   localparam logic [c_dig_w-1:0]    c_dig_last   = c_dig_w'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] c_dig_off    = DIG_OFF[NUM_DIGITS-1:0];
   localparam logic [NUM_DIGITS-1:0] c_dig_one    = NUM_DIGITS'(1);

   scan_state_t             r_state;
   scan_state_t             w_state_nxt;
   logic [c_slot_w-1:0]     r_slot_cnt;
   logic [c_dig_w-1:0]      r_digit;
   logic [6:0]              r_snap;
   logic [6:0]              w_seg_arr [NUM_DIGITS];
   logic                    w_slot_end;
   logic                    w_frame_wrap;
   logic                    w_pwm_lit;
   logic                    w_blink_dark;
   logic                    w_lit;
   logic [6:0]              w_seg_n_nxt;
   logic [NUM_DIGITS-1:0]   w_dig_n_nxt;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
         assign w_seg_arr[gi] = seg_in[7*gi +: 7];
      end
   endgenerate

   assign w_slot_end   = (r_slot_cnt == c_slot_last);
   assign w_frame_wrap = enable && w_slot_end && (r_digit == c_dig_last);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= BLANK;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = BLANK;
      end else begin
         case (r_state)
            BLANK:   if (r_slot_cnt == c_blank_last) w_state_nxt = SHOW;
            SHOW:    if (w_slot_end)                 w_state_nxt = BLANK;
            default: w_state_nxt = BLANK;
         endcase
      end
   end

   always_comb begin
      w_lit       = enable && (r_state == SHOW) && w_pwm_lit && !w_blink_dark;
      w_seg_n_nxt = SEG_OFF;
      w_dig_n_nxt = c_dig_off;
      if (w_lit) begin
         w_seg_n_nxt = ~r_snap;
         w_dig_n_nxt = ~(c_dig_one << r_digit);
      end
   end

   // ---------------------------------------------------------- counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_slot_cnt <= '0;
         r_digit    <= '0;
      end else if (!enable) begin
         r_slot_cnt <= '0;
         r_digit    <= '0;
      end else if (w_slot_end) begin
         r_slot_cnt <= '0;
         r_digit    <= (r_digit == c_dig_last) ? '0 : r_digit + 1'b1;
      end else begin
         r_slot_cnt <= r_slot_cnt + 1'b1;
      end
   end

   // Pattern is frozen for the whole slot so mid-slot edits cannot tear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_snap <= 7'd0;
      end else if (r_slot_cnt == '0) begin
         r_snap <= w_seg_arr[r_digit];
      end
   end

   seven_seg_pwm u_pwm (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (!enable || (r_state == BLANK)),
      .brightness (brightness),
      .lit        (w_pwm_lit)
   );

`ifdef SEVEN_SEG_BLINK_EN
   localparam int c_frame_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [c_frame_w-1:0] c_frame_last = c_frame_w'(BLINK_FRAMES - 1);

   logic [c_frame_w-1:0] r_frame_cnt;
   logic                 r_blink_off;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_cnt <= '0;
         r_blink_off <= 1'b0;
      end else if (w_frame_wrap) begin
         if (r_frame_cnt == c_frame_last) begin
            r_frame_cnt <= '0;
            r_blink_off <= !r_blink_off;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   assign w_blink_dark = r_blink_off && blink_mask[r_digit];
`else
   logic w_unused_blink;
   assign w_unused_blink = ^{blink_mask, 32'(BLINK_FRAMES)};
   assign w_blink_dark   = 1'b0;
`endif

   // ------------------------------------------------------------ outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_n      <= SEG_OFF;
         dig_n      <= c_dig_off;
         frame_tick <= 1'b0;
      end else begin
         seg_n      <= w_seg_n_nxt;
         dig_n      <= w_dig_n_nxt;
         frame_tick <= w_frame_wrap;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_seg_scan_driver
// Purpose : Self-checking bench: slot-arithmetic model plus directed pins.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seven_seg_scan_driver;

   localparam int N     = 3;
   localparam int DIV   = 40;
   localparam int BLK   = 4;
   localparam int BFR   = 2;
   localparam int FRAME = N * DIV;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            enable;
   logic [N*7-1:0]  seg_in;
   logic [3:0]      brightness;
   logic [N-1:0]    blink_mask;
   logic [6:0]      seg_n;
   logic [N-1:0]    dig_n;
   logic            frame_tick;

   int tests = 0;
   int fails = 0;
   int k     = 0;
   bit chk_on = 1'b0;

   seven_seg_scan_driver #(
      .NUM_DIGITS   (N),
      .SCAN_DIV     (DIV),
      .BLANK_CYCLES (BLK),
      .BLINK_FRAMES (BFR)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .seg_in     (seg_in),
      .brightness (brightness),
      .blink_mask (blink_mask),
      .seg_n      (seg_n),
      .dig_n      (dig_n),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // Reference: time since scan (re)start decides digit, slot position, PWM.
   int         t     = 0;
   int         ticks = 0;
   logic [6:0] msnap [N];
   logic [6:0] exp_seg  = 7'h7F;
   logic [N-1:0] exp_dig = '1;
   logic       exp_tick = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      int  slot, pos;
      bit  lit;
      logic [N-1:0] one;
      one = 1;
      if (!reset_n) begin
         t = 0; ticks = 0;
         exp_seg = 7'h7F; exp_dig = '1; exp_tick = 1'b0;
      end else if (!enable) begin
         t = 0;
         exp_seg = 7'h7F; exp_dig = '1; exp_tick = 1'b0;
      end else begin
         slot = (t / DIV) % N;
         pos  = t % DIV;
         if (pos == 0) msnap[slot] = seg_in[7*slot +: 7];
         lit = (pos >= BLK) && ((brightness == 15) || (((pos - BLK) % 16) < brightness));
`ifdef SEVEN_SEG_BLINK_EN
         if ((((ticks / BFR) % 2) == 1) && blink_mask[slot]) lit = 0;
`endif
         exp_dig  = lit ? ~(one << slot) : '1;
         exp_seg  = lit ? ~msnap[slot] : 7'h7F;
         exp_tick = (pos == DIV - 1) && (slot == N - 1);
         if (exp_tick) ticks++;
         t = (t + 1) % FRAME;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         tests++;
         if (seg_n !== exp_seg || dig_n !== exp_dig || frame_tick !== exp_tick) begin
            fails++;
            $display("FAIL model @%0t: seg_n=%h dig_n=%b tick=%b, expected seg_n=%h dig_n=%b tick=%b",
                     $time, seg_n, dig_n, frame_tick, exp_seg, exp_dig, exp_tick);
         end
         tests++;
         if ($countones(~dig_n) > 1) begin
            fails++;
            $display("FAIL onehot @%0t: dig_n=%b, expected at most one low", $time, dig_n);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (k=%0d): got %h, expected %h", name, k, act, exp);
      end
   endtask

   task automatic step_to(input int target);
      while (k < target) begin
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      int lows;
      int guard;
      reset_n    = 1'b0;
      enable     = 1'b1;
      brightness = 4'd15;
      blink_mask = '0;
      seg_in     = {7'h06, 7'h5B, 7'h3F};
      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      check("reset_seg", seg_n, 7'h7F);
      check("reset_dig", dig_n, 3'b111);
      check("reset_tick", frame_tick, 1'b0);
      reset_n = 1'b1;
      k = 0;

      // basic scan
      step_to(4);   check("blank_dig0", dig_n, 3'b111);
      step_to(5);   check("show_dig0", dig_n, 3'b110); check("show_seg0", seg_n, 7'h40);
      step_to(40);  check("end_dig0", dig_n, 3'b110);
      step_to(41);  check("blank_dig1", dig_n, 3'b111);
      step_to(45);  check("show_dig1", dig_n, 3'b101); check("show_seg1", seg_n, 7'h24);
      step_to(85);  check("show_dig2", dig_n, 3'b011); check("show_seg2", seg_n, 7'h79);
      step_to(119); check("pre_tick", frame_tick, 1'b0);
      step_to(120); check("frame_tick", frame_tick, 1'b1);
      step_to(121); check("tick_width", frame_tick, 1'b0);

      // mid-slot pattern change
      step_to(130); seg_in[6:0] = 7'h06;
      step_to(135); check("snap_hold", seg_n, 7'h40);
      step_to(245); check("snap_next", seg_n, 7'h79);

      // PWM
      step_to(360); brightness = 4'd4; lows = 0;
      while (k < 400) begin step_to(k + 1); if (dig_n != 3'b111) lows++; end
      check("pwm4_lows", lows, 12);
      brightness = 4'd0; lows = 0;
      while (k < 520) begin step_to(k + 1); if (dig_n != 3'b111) lows++; end
      check("pwm0_lows", lows, 0);
      brightness = 4'd15;

      // enable drop mid digit 1
      step_to(540); check("pre_drop", dig_n, 3'b101);
      enable = 1'b0;
      step_to(541); check("drop_dig", dig_n, 3'b111); check("drop_seg", seg_n, 7'h7F);
      step_to(545); enable = 1'b1;
      step_to(664); check("restart_pre_tick", frame_tick, 1'b0);
      step_to(665); check("restart_tick", frame_tick, 1'b1);

      // async reset in SHOW
      guard = 0;
      while (dig_n == 3'b111 && guard < 100) begin step_to(k + 1); guard++; end
      check("wait_lit_timeout", guard < 100, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      check("async_seg", seg_n, 7'h7F);
      check("async_dig", dig_n, 3'b111);
      check("async_tick", frame_tick, 1'b0);
      seg_in     = {7'h06, 7'h5B, 7'h3F};
      blink_mask = 3'b010;
      @(negedge clk);
      reset_n = 1'b1;
      k = 0;

      // blink over six frames
      for (int f = 0; f < 6; f++) begin
         step_to(f * FRAME + 20);
         check("blink_d0", dig_n, 3'b110);
         step_to(f * FRAME + 60);
`ifdef SEVEN_SEG_BLINK_EN
         check("blink_d1", dig_n, (f == 2 || f == 3) ? 3'b111 : 3'b101);
`else
         check("blink_d1", dig_n, 3'b101);
`endif
         step_to(f * FRAME + 100);
         check("blink_d2", dig_n, 3'b011);
      end

      // randomized run, checked by the model every cycle
      for (int it = 0; it < 40; it++) begin
         seg_in     = N*7'($urandom);
         blink_mask = N'($urandom);
         case ($urandom_range(0, 3))
            0:       brightness = 4'd15;
            1:       brightness = 4'd0;
            default: brightness = 4'($urandom);
         endcase
         if ($urandom_range(0, 7) == 0) begin
            enable = 1'b0;
            step_to(k + $urandom_range(1, 10));
            enable = 1'b1;
         end
         step_to(k + $urandom_range(20, 400));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
